elevator_scan_controller: RTL and testbench

Parametrised successor to the single-request elevator controller. It latches multiple hall/car calls into a pending bitmask and serves them in SCAN (collective) order: it keeps its direction while calls remain ahead and reverses otherwise. It models per-floor travel time and door dwell time internally, and holds the door on overtime or overweight conditions. It sits between the call-button decode logic and the motor/door drivers.

---
 rtl/elevator_scan_controller.sv | 182 ++++++++++++++++++
 tb/tb_elevator_scan_controller.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_controller.sv
// SCAN (collective) elevator controller.
// Latches hall/car calls into a pending mask. The car keeps its direction
// while calls remain ahead of it and reverses when none do. Travel time per
// floor and door dwell time are modelled with internal counters. Overweight
// and door-held sensors keep the door open.
//
// state | meaning
// IDLE  | car parked with its door closed, waiting for a pending call
// MOVE  | travelling one floor per TRAVEL_CYCLES in the current direction
// DOOR  | door open at current_floor, dwelling or held by a sensor
module elevator_scan_controller #(
    parameter int N_FLOORS      = 8,
    parameter int FLOOR_W       = $clog2(N_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_FLOORS-1:0] call_req,
    input  logic                over_time,
    input  logic                over_weight,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                direction,
    output logic                moving,
    output logic                door_open,
    output logic                complete,
    output logic                timer_alert,
    output logic                weight_alert
);

    localparam int TRAV_W = $clog2(TRAVEL_CYCLES + 1);
    localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);
    localparam logic [TRAV_W-1:0] TRAV_LAST = TRAV_W'(TRAVEL_CYCLES - 1);
    localparam logic [DOOR_W-1:0] DOOR_LAST = DOOR_W'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_DOOR = 2'd2
    } state_t;

    state_t              state, state_d, dec_state;
    logic [FLOOR_W-1:0]  floor_d, next_floor;
    logic [N_FLOORS-1:0] pending_d, pend_or, clr, cf_onehot, nf_onehot;
    logic [TRAV_W-1:0]   travel_cnt, travel_d;
    logic [DOOR_W-1:0]   door_cnt, door_d;
    logic                dir_d, dec_dir;
    logic                complete_d, timer_d, weight_d;
    logic                above, below, here, door_tc;

    assign moving    = (state == ST_MOVE);
    assign door_open = (state == ST_DOOR);

    assign pend_or    = pending | call_req;
    assign here       = pending[current_floor];
    assign door_tc    = (door_cnt == DOOR_LAST);
    assign next_floor = direction ? current_floor + FLOOR_W'(1)
                                  : current_floor - FLOOR_W'(1);
    assign cf_onehot  = N_FLOORS'(1) << current_floor;
    assign nf_onehot  = N_FLOORS'(1) << next_floor;

    // Summarise the registered calls relative to the car position.
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i]) begin
                if (i > int'(current_floor)) above = 1'b1;
                if (i < int'(current_floor)) below = 1'b1;
            end
        end
    end

    // SCAN decision: serve here, else keep heading up while calls remain
    // above (or nothing is below), else head down, else park.
    always_comb begin
        dec_state = ST_IDLE;
        dec_dir   = direction;
        if (here) begin
            dec_state = ST_DOOR;
        end else if (above && (direction || !below)) begin
            dec_state = ST_MOVE;
            dec_dir   = 1'b1;
        end else if (below) begin
            dec_state = ST_MOVE;
            dec_dir   = 1'b0;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        floor_d    = current_floor;
        dir_d      = direction;
        travel_d   = travel_cnt;
        door_d     = door_cnt;
        clr        = '0;
        complete_d = 1'b0;
        timer_d    = 1'b0;
        weight_d   = 1'b0;

        case (state)
            ST_IDLE: begin
                // A call at the parked floor opens the door without a
                // complete pulse: the car did not arrive, it was already here.
                state_d  = dec_state;
                dir_d    = dec_dir;
                travel_d = '0;
                door_d   = '0;
                if (dec_state == ST_DOOR) clr = cf_onehot;
            end
            ST_MOVE: begin
                if (travel_cnt == TRAV_LAST) begin
                    travel_d = '0;
                    floor_d  = next_floor;
                    if (pend_or[next_floor]) begin
                        state_d    = ST_DOOR;
                        clr        = nf_onehot;
                        complete_d = 1'b1;
                        door_d     = '0;
                    end
                end else begin
                    travel_d = travel_cnt + TRAV_W'(1);
                end
            end
            ST_DOOR: begin
                // Alerts are registered together with the state; every case
                // that raises one also keeps the car in DOOR.
                timer_d  = door_tc && over_time;
                weight_d = over_weight;
                if (call_req[current_floor]) begin
                    clr    = cf_onehot;
                    door_d = '0;
                end else if (over_weight) begin
                    door_d = door_cnt;
                end else if (door_tc) begin
                    if (!over_time) begin
                        state_d  = dec_state;
                        dir_d    = dec_dir;
                        travel_d = '0;
                        door_d   = '0;
                        if (dec_state == ST_DOOR) clr = cf_onehot;
                    end
                end else begin
                    door_d = door_cnt + DOOR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pending_d = pend_or & ~clr;
    end

    // State, position, call mask, counters and registered pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_IDLE;
            current_floor <= '0;
            pending       <= '0;
            direction     <= 1'b1;
            travel_cnt    <= '0;
            door_cnt      <= '0;
            complete      <= 1'b0;
            timer_alert   <= 1'b0;
            weight_alert  <= 1'b0;
        end else begin
            state         <= state_d;
            current_floor <= floor_d;
            pending       <= pending_d;
            direction     <= dir_d;
            travel_cnt    <= travel_d;
            door_cnt      <= door_d;
            complete      <= complete_d;
            timer_alert   <= timer_d;
            weight_alert  <= weight_d;
        end
    end

endmodule

// File: tb/tb_elevator_scan_controller.sv
// Scoreboard bench for elevator_scan_controller: a behavioural car model
// predicts every cycle's outputs and every arrival; monitors compare them.
module tb_elevator_scan_controller;

    localparam int N     = 8;
    localparam int FW    = 3;
    localparam int TC    = 4;
    localparam int DC    = 6;
    localparam int OUT_W = FW + N + 6;

    localparam int MODE_REST   = 0;
    localparam int MODE_TRAVEL = 1;
    localparam int MODE_DWELL  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  call_req = '0;
    logic          over_time = 1'b0;
    logic          over_weight = 1'b0;
    logic [FW-1:0] current_floor;
    logic [N-1:0]  pending;
    logic          direction, moving, door_open, complete;
    logic          timer_alert, weight_alert;

    elevator_scan_controller #(
        .N_FLOORS(N), .FLOOR_W(FW), .TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .call_req(call_req),
        .over_time(over_time), .over_weight(over_weight),
        .current_floor(current_floor), .pending(pending),
        .direction(direction), .moving(moving), .door_open(door_open),
        .complete(complete), .timer_alert(timer_alert),
        .weight_alert(weight_alert)
    );

    initial forever #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t",
                      name, act, req, $time);
    endtask

    // ---------------- behavioural model ----------------
    int           m_floor, m_dir, m_mode, m_trav, m_dwell, m_served;
    logic [N-1:0] m_pend;
    bit           m_comp, m_ta, m_wa;

    logic [OUT_W-1:0] exp_q[$];
    int               arr_q[$];

    function automatic bit calls_above(input logic [N-1:0] p, input int f);
        for (int i = f + 1; i < N; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit calls_below(input logic [N-1:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor = 0; m_dir = 1; m_mode = MODE_REST; m_trav = 0; m_dwell = 0;
        m_pend = '0; m_comp = 0; m_ta = 0; m_wa = 0;
    endtask

    // Choose what to do next from the calls known before this edge.
    task automatic model_decide(input logic [N-1:0] p);
        m_trav  = 0;
        m_dwell = 0;
        if (p[m_floor]) begin
            m_mode   = MODE_DWELL;
            m_served = m_floor;
        end else if (calls_above(p, m_floor) &&
                     (m_dir == 1 || !calls_below(p, m_floor))) begin
            m_dir  = 1;
            m_mode = MODE_TRAVEL;
        end else if (calls_below(p, m_floor)) begin
            m_dir  = 0;
            m_mode = MODE_TRAVEL;
        end else begin
            m_mode = MODE_REST;
        end
    endtask

    task automatic model_step(input logic [N-1:0] c, input bit ot, input bit ow);
        logic [N-1:0] old_p;
        logic [N-1:0] seen;
        old_p    = m_pend;
        seen     = old_p | c;
        m_served = -1;
        m_comp   = 0;
        m_ta     = 0;
        m_wa     = 0;
        case (m_mode)
            MODE_REST: model_decide(old_p);
            MODE_TRAVEL: begin
                if (m_trav == TC - 1) begin
                    m_trav  = 0;
                    m_floor = m_floor + (m_dir == 1 ? 1 : -1);
                    if (seen[m_floor]) begin
                        m_mode   = MODE_DWELL;
                        m_dwell  = 0;
                        m_served = m_floor;
                        m_comp   = 1;
                    end
                end else begin
                    m_trav++;
                end
            end
            default: begin
                m_wa = ow;
                m_ta = (m_dwell == DC - 1) && ot;
                if (c[m_floor]) begin
                    m_served = m_floor;
                    m_dwell  = 0;
                end else if (ow) begin
                    // door held, dwell frozen
                end else if (m_dwell == DC - 1) begin
                    if (!ot) model_decide(old_p);
                end else begin
                    m_dwell++;
                end
            end
        endcase
        m_pend = seen;
        if (m_served >= 0) m_pend[m_served] = 1'b0;
    endtask

    function automatic logic [OUT_W-1:0] model_vec();
        return {FW'(m_floor), m_pend, (m_dir == 1), (m_mode == MODE_TRAVEL),
                (m_mode == MODE_DWELL), m_comp, m_ta, m_wa};
    endfunction

    function automatic logic [OUT_W-1:0] dut_vec();
        return {current_floor, pending, direction, moving, door_open,
                complete, timer_alert, weight_alert};
    endfunction

    // Model advances on each rising edge and queues its expectations.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!rst) begin
                model_reset();
                arr_q.delete();
            end else begin
                model_step(call_req, over_time, over_weight);
            end
            exp_q.push_back(model_vec());
            if (m_comp) arr_q.push_back(m_floor);
        end
    end

    // Monitor: compares on the falling edge, away from the active edge.
    initial begin
        logic [OUT_W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", 32'(dut_vec()), 32'(e));
            end
            check("floor_range", 32'(int'(current_floor) < N), 32'd1);
            if (complete === 1'b1) begin
                if (arr_q.size() > 0)
                    check("arrival_floor", 32'(current_floor), 32'(arr_q.pop_front()));
                else
                    check("arrival_unexpected", 32'(complete), 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [N-1:0] v);
        call_req = v;
        @(negedge clk);
        call_req = '0;
    endtask

    task automatic wait_door(input string name, input int max);
        int i = 0;
        while (door_open !== 1'b1 && i < max) begin
            @(negedge clk);
            i++;
        end
        check(name, 32'(door_open), 32'd1);
    endtask

    localparam logic [OUT_W-1:0] RESET_VEC = {3'd0, 8'd0, 1'b1, 5'b00000};

    initial begin
        logic [OUT_W-1:0] rv;
        rv = RESET_VEC;
        cycles(3);
        rst = 1'b1;
        cycles(1);

        // 1: single call three floors up, then park
        pulse(8'b0000_1000);
        cycles(30);

        // 2: car moving up from 3, calls above and below join mid-trip
        pulse(8'b1000_0000);
        cycles(3);
        pulse(8'b0010_0010);
        cycles(120);

        // 3: door held by over_time across the end of its dwell
        pulse(8'b0010_0000);
        wait_door("wait_door_f5", 100);
        over_time = 1'b1;
        cycles(DC + 3);
        over_time = 1'b0;
        cycles(12);

        // 4: overweight freezes the dwell for 10 cycles
        pulse(8'b0100_0000);
        wait_door("wait_door_f6", 100);
        over_weight = 1'b1;
        cycles(10);
        over_weight = 1'b0;
        cycles(14);

        // 5: same-floor calls while parked and while the door is open
        pulse(8'b0000_0100);
        wait_door("wait_door_f2", 100);
        cycles(10);
        pulse(8'b0000_0100);
        cycles(3);
        pulse(8'b0000_0100);
        cycles(12);

        // 6: reset between floors 4 and 5
        pulse(8'b0010_0000);
        begin
            int i = 0;
            while (!(current_floor == 3'd4 && moving === 1'b1) && i < 100) begin
                @(negedge clk);
                i++;
            end
            check("wait_floor4", 32'(current_floor), 32'd4);
        end
        cycles(2);
        #2 rst = 1'b0;
        #1 check("reset_async", 32'(dut_vec()), 32'(rv));
        cycles(2);
        rst = 1'b1;
        cycles(4);

        // randomized traffic with sparse calls and sensor activity
        for (int k = 0; k < 2500; k++) begin
            call_req    = ($urandom_range(0, 5) == 0) ?
                          N'($urandom & $urandom) : '0;
            over_time   = ($urandom_range(0, 7) == 0);
            over_weight = ($urandom_range(0, 11) == 0);
            @(negedge clk);
        end
        call_req    = '0;
        over_time   = 1'b0;
        over_weight = 1'b0;
        cycles(300);

        check("arrivals_drained", 32'(arr_q.size()), 32'd0);
        check("final_pending", 32'(pending), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
